// File: rtl/multdiv_seq.sv
// multdiv_seq: iterative signed multiply (shift-add) / divide (restoring) unit, one bit per cycle
module multdiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} stateT;
   stateT state, nextState;
   logic [CW-1:0] iterCnt;
   logic [WIDTH-1:0] opM, acc, lo, magA, magB, divRes;
   logic negRes, divGe, divExc, mulExc;
   logic [WIDTH:0] mulSum, divShift, divDiff;
   logic [2*WIDTH-1:0] prodMag, prodS;
   always_comb begin
      nextState = IDLE;
      if (ctrl_MULT) nextState = MUL;
      else if (ctrl_DIV) nextState = DIV;
      else if (state == MUL || state == DIV) nextState = (iterCnt == '0) ? DONE : state;
   end
   // opM is the multiplicand or divisor magnitude; lo holds multiplier bits or the forming quotient
   always_comb begin
      magA = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
      magB = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
      mulSum = {1'b0, acc} + {1'b0, lo[0] ? opM : '0};
      divShift = {acc, lo[WIDTH-1]};
      divDiff = divShift - {1'b0, opM};
      divGe = ~divDiff[WIDTH];
      prodMag = {acc, lo};
      prodS = negRes ? -prodMag : prodMag;
      mulExc = ~(&prodS[2*WIDTH-1:WIDTH-1]) & (|prodS[2*WIDTH-1:WIDTH-1]);
      divRes = (opM == '0) ? '0 : negRes ? -lo : lo;
      divExc = (opM == '0) | (~negRes & lo[WIDTH-1]);
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else state <= nextState;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         iterCnt <= '0;
         opM <= '0;
         acc <= '0;
         lo <= '0;
         negRes <= 1'b0;
         data_result <= '0;
         data_exception <= 1'b0;
      end else if (ctrl_MULT || ctrl_DIV) begin
         opM <= ctrl_MULT ? magA : magB;
         lo <= ctrl_MULT ? magB : magA;
         acc <= '0;
         iterCnt <= CW'(WIDTH);
         negRes <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      end else if (state == MUL) begin
         if (iterCnt != '0) begin
            acc <= mulSum[WIDTH:1];
            lo <= {mulSum[0], lo[WIDTH-1:1]};
            iterCnt <= iterCnt - CW'(1);
         end else begin
            data_result <= prodS[WIDTH-1:0];
            data_exception <= mulExc;
         end
      end else if (state == DIV) begin
         if (iterCnt != '0) begin
            acc <= divGe ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
            lo <= {lo[WIDTH-2:0], divGe};
            iterCnt <= iterCnt - CW'(1);
         end else begin
            data_result <= divRes;
            data_exception <= divExc;
         end
      end
   end
   assign busy = (state == MUL) || (state == DIV);
   assign data_resultRDY = (state == DONE);
endmodule

// File: tb/tb_multdiv_seq.sv
// tb_multdiv_seq: directed and random checks of multdiv_seq against a plain-arithmetic reference
module tb_multdiv_seq;
   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [31:0] data_operandA = '0, data_operandB = '0;
   logic ctrl_MULT = 1'b0, ctrl_DIV = 1'b0;
   logic [31:0] data_result;
   logic data_exception, data_resultRDY, busy;
   int nAssert = 0, nFail = 0;

   multdiv_seq #(.WIDTH(32)) dut (
      .clock(clock), .reset(reset),
      .data_operandA(data_operandA), .data_operandB(data_operandB),
      .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
      .data_result(data_result), .data_exception(data_exception),
      .data_resultRDY(data_resultRDY), .busy(busy)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nAssert++;
      assert (obs === exp) else begin
         nFail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void model(input bit isMul, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e);
      longint p;
      if (isMul) begin
         p = longint'($signed(a)) * longint'($signed(b));
         r = p[31:0];
         e = (p > 64'sd2147483647) || (p < -64'sd2147483648);
      end else if (b == 32'd0) begin
         r = '0;
         e = 1'b1;
      end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
         r = a;
         e = 1'b1;
      end else begin
         r = $signed(a) / $signed(b);
         e = 1'b0;
      end
   endfunction

   // Drives a start for one edge, then scrambles operands to show they were latched
   task automatic startOp(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
      @(negedge clock);
      ctrl_MULT = m;
      ctrl_DIV = d;
      data_operandA = a;
      data_operandB = b;
      @(posedge clock);
      #1;
      ctrl_MULT = 1'b0;
      ctrl_DIV = 1'b0;
      data_operandA = $urandom;
      data_operandB = $urandom;
   endtask

   task automatic waitResult(input string tag, input logic [31:0] er, input logic ee);
      bit badWin = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         @(posedge clock);
         #1;
         if (busy !== 1'b1 || data_resultRDY !== 1'b0) badWin = 1'b1;
      end
      check({tag, " busyWindow"}, {31'd0, badWin}, 32'd0);
      @(posedge clock);
      #1;
      check({tag, " rdy"}, {31'd0, data_resultRDY}, 32'd1);
      check({tag, " busyDone"}, {31'd0, busy}, 32'd0);
      check({tag, " result"}, data_result, er);
      check({tag, " exc"}, {31'd0, data_exception}, {31'd0, ee});
      @(posedge clock);
      #1;
      check({tag, " rdyPulse"}, {31'd0, data_resultRDY}, 32'd0);
      check({tag, " hold"}, data_result, er);
   endtask

   task automatic runOp(input string tag, input bit isMul, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] er;
      logic ee;
      model(isMul, a, b, er, ee);
      startOp(isMul, !isMul, a, b);
      waitResult(tag, er, ee);
   endtask

   initial begin
      logic [31:0] er, a, b;
      logic ee;
      bit sawRdy;
      #1;
      check("resetResult", data_result, 32'd0);
      check("resetFlags", {28'd0, data_exception, data_resultRDY, busy, 1'b0}, 32'd0);
      @(negedge clock);
      reset = 1'b0;

      runOp("mul7x-3", 1'b1, 32'd7, -32'sd3);
      check("mul7x-3 golden", data_result, 32'hFFFFFFEB);
      runOp("mulOvf", 1'b1, 32'h00010000, 32'h00010000);
      runOp("mulNegNeg", 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      runOp("div-7/2", 1'b0, -32'sd7, 32'd2);
      check("div-7/2 golden", data_result, 32'hFFFFFFFD);
      runOp("div100/7", 1'b0, 32'd100, 32'd7);
      runOp("div3/-5", 1'b0, 32'd3, -32'sd5);
      runOp("divZero", 1'b0, 32'd5, 32'd0);
      runOp("divMinNeg1", 1'b0, 32'h80000000, 32'hFFFFFFFF);
      runOp("mulMin", 1'b1, 32'h80000000, 32'd1);
      runOp("mulMinNeg1", 1'b1, 32'h80000000, 32'hFFFFFFFF);

      // Restart a multiply with a divide at edge 10
      startOp(1'b1, 1'b0, 32'd6, 32'd7);
      sawRdy = 1'b0;
      for (int k = 1; k <= 9; k++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY) sawRdy = 1'b1;
      end
      check("restart early rdy", {31'd0, sawRdy}, 32'd0);
      startOp(1'b0, 1'b1, 32'd100, 32'd7);
      waitResult("restart", 32'd14, 1'b0);

      startOp(1'b1, 1'b1, 32'd6, 32'd3);
      waitResult("bothStart", 32'd18, 1'b0);

      // Async reset mid-multiply
      startOp(1'b1, 1'b0, 32'd12345, 32'd678);
      repeat (14) @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      check("rstMid busy", {31'd0, busy}, 32'd0);
      check("rstMid rdy", {31'd0, data_resultRDY}, 32'd0);
      check("rstMid result", data_result, 32'd0);
      check("rstMid exc", {31'd0, data_exception}, 32'd0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      sawRdy = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clock);
         #1;
         if (data_resultRDY || busy) sawRdy = 1'b1;
      end
      check("rstMid quiet", {31'd0, sawRdy}, 32'd0);
      runOp("afterReset", 1'b1, -32'sd9, 32'd11);

      for (int i = 0; i < 30; i++) begin
         bit isMul;
         isMul = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 4))
            0: begin a = $urandom_range(0, 2000) - 1000; b = $urandom_range(0, 200) - 100; end
            1: begin a = $urandom; b = $urandom; end
            2: begin a = $urandom; b = '0; end
            3: begin a = 32'h80000000; b = $urandom_range(0, 1) ? 32'hFFFFFFFF : $urandom; end
            default: begin a = $urandom; b = $urandom >> $urandom_range(0, 31); end
         endcase
         model(isMul, a, b, er, ee);
         startOp(isMul, !isMul, a, b);
         waitResult(isMul ? "randMul" : "randDiv", er, ee);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end
endmodule
